mskaes_key_loader: RTL and testbench

MSKAES_KEY_LOADER -- requirements
Module: mskaes_key_loader

---
 rtl/mskaes_key_loader.sv | 104 ++++++++++
 tb/tb_mskaes_key_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mskaes_key_loader.sv
// Collects a masked AES key word by word, hands it to the key datapath with a
// single init strobe, then erases the buffer. Shares are stored, never combined.
module mskaes_key_loader #(
    parameter int d = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_256,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [32*d-1:0]   in_data,
    input  logic              clear,
    input  logic              core_idle,
    output logic              key_valid,
    output logic              init,
    output logic [256*d-1:0]  sh_key
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        FULL = 2'd1,
        LOAD = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       len_q, len_d;
    logic       accept;
    logic       len_eff;
    logic       last_word;
    logic       flush;

    // A clear in the same cycle as a handshake drops the word.
    assign accept    = in_valid && (state_q == FILL) && !clear;
    assign len_eff   = (cnt_q == 3'd0) ? key_256 : len_q;
    assign last_word = len_eff ? (cnt_q == 3'd7) : (cnt_q == 3'd3);
    assign flush     = clear || (state_q == LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            cnt_q   <= 3'd0;
            len_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd0) len_d = key_256;
                    if (last_word) state_d = FULL;
                end
            end
            FULL: begin
                if (core_idle) state_d = LOAD;
            end
            LOAD: begin
                state_d = FILL;
                cnt_d   = 3'd0;
            end
            default: begin
                state_d = FILL;
                cnt_d   = 3'd0;
            end
        endcase
        if (clear) begin
            state_d = FILL;
            cnt_d   = 3'd0;
            len_d   = 1'b0;
        end
    end

    // One register per key word; words beyond the key length are never written,
    // so a 128-bit key leaves words 4..7 at zero.
    for (genvar gi = 0; gi < 8; gi++) begin : gen_word
        logic [32*d-1:0] word_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_q <= '0;
            end else if (flush) begin
                word_q <= '0;
            end else if (accept && (cnt_q == 3'(gi))) begin
                word_q <= in_data;
            end
        end

        assign sh_key[32*d*gi +: 32*d] = word_q;
    end

    assign in_ready  = (state_q == FILL);
    assign key_valid = (state_q == FULL) || (state_q == LOAD);
    assign init      = (state_q == LOAD);

endmodule

// File: tb/tb_mskaes_key_loader.sv
// Directed and randomized checks of the masked key loader against a word-array
// model of the expected key.
module tb_mskaes_key_loader;

    localparam int D  = 2;
    localparam int WW = 32 * D;
    localparam int KW = 256 * D;

    logic          clk;
    logic          rst_n;
    logic          key_256;
    logic          in_valid;
    logic          in_ready;
    logic [WW-1:0] in_data;
    logic          clear;
    logic          core_idle;
    logic          key_valid;
    logic          init;
    logic [KW-1:0] sh_key;

    int checks;
    int failures;
    logic [WW-1:0] exp_words [8];
    logic          exp_256;
    int            pulses;

    mskaes_key_loader #(.d(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_256   (key_256),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .clear     (clear),
        .core_idle (core_idle),
        .key_valid (key_valid),
        .init      (init),
        .sh_key    (sh_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
        $display("check %s observed=%0b expected=%0b", tag, obs, exp);
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic chkk(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s key=%0h", tag, obs);
    endtask

    // Key as the core should see it: words in order, unused upper half zero.
    function automatic logic [KW-1:0] model_key();
        logic [KW-1:0] k;
        k = '0;
        for (int w = 0; w < 8; w++)
            if (w < 4 || exp_256) k[WW*w +: WW] = exp_words[w];
        return k;
    endfunction

    function automatic logic [WW-1:0] pattern_word(input int w);
        logic [WW-1:0] v;
        logic [7:0]    byte_val;
        for (int b = 0; b < 4; b++) begin
            byte_val = 8'(8'h10 * w + b);
            for (int s = 0; s < D; s++) v[8*D*b + 8*s +: 8] = byte_val;
        end
        return v;
    endfunction

    function automatic logic [WW-1:0] rand_word();
        logic [WW-1:0] v;
        for (int i = 0; i < D; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one word and completes the handshake within a bounded wait.
    task automatic send_word(input int w, input logic [WW-1:0] data, input logic k);
        int n;
        n = 0;
        in_data  = data;
        key_256  = k;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $error("FAIL handshake_timeout observed=in_ready_low expected=in_ready_high");
        end
        tick();
        in_valid = 1'b0;
        exp_words[w] = data;
        if (w == 0) exp_256 = k;
        $display("word w=%0d data=%0h key_256=%0b", w, data, k);
    endtask

    task automatic clear_model();
        for (int w = 0; w < 8; w++) exp_words[w] = '0;
        exp_256 = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        key_256   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        clear     = 1'b0;
        core_idle = 1'b0;
        clear_model();

        // Reset state
        #23;
        chkk("reset_sh_key", sh_key, '0);
        chk1("reset_key_valid", key_valid, 1'b0);
        chk1("reset_init", init, 1'b0);
        rst_n = 1'b1;
        tick();
        chk1("release_in_ready", in_ready, 1'b1);
        chk1("release_key_valid", key_valid, 1'b0);

        // 8 back-to-back patterned words, AES-256, core always idle
        core_idle = 1'b1;
        for (int w = 0; w < 8; w++) send_word(w, pattern_word(w), 1'b1);
        chk1("k256_key_valid", key_valid, 1'b1);
        chk1("k256_in_ready", in_ready, 1'b0);
        chk1("k256_init_before", init, 1'b0);
        chkk("k256_sh_key", sh_key, model_key());
        tick();
        chk1("k256_init", init, 1'b1);
        chk1("k256_valid_in_load", key_valid, 1'b1);
        chkk("k256_sh_key_load", sh_key, model_key());
        tick();
        chk1("k256_init_after", init, 1'b0);
        chk1("k256_valid_after", key_valid, 1'b0);
        chk1("k256_ready_after", in_ready, 1'b1);
        chkk("k256_erased", sh_key, '0);
        clear_model();

        // AES-128 with key_256 raised after the first word
        core_idle = 1'b0;
        send_word(0, rand_word(), 1'b0);
        for (int w = 1; w < 4; w++) send_word(w, rand_word(), 1'b1);
        chk1("k128_key_valid", key_valid, 1'b1);
        chk1("k128_in_ready", in_ready, 1'b0);
        chkk("k128_sh_key", sh_key, model_key());
        in_valid = 1'b1;
        in_data  = rand_word();
        tick();
        chkk("k128_full_ignores_words", sh_key, model_key());
        in_valid  = 1'b0;
        core_idle = 1'b1;
        tick();
        chk1("k128_init", init, 1'b1);
        chkk("k128_sh_key_load", sh_key, model_key());
        tick();
        chk1("k128_init_single", init, 1'b0);
        chkk("k128_erased", sh_key, '0);
        clear_model();

        // Core busy for 20 cycles, then exactly one init
        core_idle = 1'b0;
        for (int w = 0; w < 8; w++) send_word(w, rand_word(), 1'b1);
        for (int c = 0; c < 20; c++) begin
            chk1("busy_key_valid", key_valid, 1'b1);
            chk1("busy_in_ready", in_ready, 1'b0);
            chk1("busy_init", init, 1'b0);
            tick();
        end
        chkk("busy_sh_key", sh_key, model_key());
        core_idle = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (init === 1'b1) pulses++;
        end
        chkn("busy_init_pulses", pulses, 1);
        chkk("busy_erased", sh_key, '0);
        clear_model();

        // Clear colliding with word 5
        core_idle = 1'b0;
        for (int w = 0; w < 5; w++) send_word(w, rand_word(), 1'b1);
        in_valid = 1'b1;
        in_data  = rand_word();
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        clear_model();
        chkk("clear_sh_key", sh_key, '0);
        chk1("clear_in_ready", in_ready, 1'b1);
        chk1("clear_key_valid", key_valid, 1'b0);
        for (int w = 0; w < 8; w++) send_word(w, rand_word(), 1'b1);
        chk1("clear_reload_valid", key_valid, 1'b1);
        chkk("clear_reload_key", sh_key, model_key());
        core_idle = 1'b1;
        tick();
        chk1("clear_reload_init", init, 1'b1);
        tick();
        clear_model();

        // Asynchronous reset in the middle of a gapped fill
        for (int w = 0; w < 3; w++) begin
            send_word(w, rand_word(), 1'b1);
            repeat ($urandom_range(1, 3)) tick();
        end
        in_valid = 1'b1;
        in_data  = rand_word();
        #2;
        rst_n = 1'b0;
        #1;
        clear_model();
        chkk("arst_sh_key", sh_key, '0);
        chk1("arst_key_valid", key_valid, 1'b0);
        chk1("arst_init", init, 1'b0);
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (init === 1'b1) pulses++;
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (init === 1'b1) pulses++;
        end
        chkn("arst_no_init", pulses, 0);
        chk1("arst_in_ready", in_ready, 1'b1);
        chkk("arst_still_zero", sh_key, '0);
        core_idle = 1'b0;
        for (int w = 0; w < 4; w++) begin
            send_word(w, rand_word(), 1'b0);
            repeat ($urandom_range(0, 2)) tick();
        end
        chk1("arst_reload_valid", key_valid, 1'b1);
        chkk("arst_reload_key", sh_key, model_key());
        core_idle = 1'b1;
        tick();
        chk1("arst_reload_init", init, 1'b1);
        tick();
        chkk("arst_reload_erased", sh_key, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
